// File: rtl/wave_gen.sv
// Programmable trapezoid / triangle / sawtooth / square waveform generator.
// Waveform parameters are shadowed per period so changes land on period boundaries.
module wave_gen #(
    parameter int DW = 9,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] peak,
    input  logic [DW-1:0] step,
    input  logic [CW-1:0] dwell,
    output logic [DW-1:0] d_out,
    output logic [1:0]    phase,
    output logic          period_done
);

    typedef enum logic [1:0] {
        RISE   = 2'd0,
        TOP    = 2'd1,
        FALL   = 2'd2,
        BOTTOM = 2'd3
    } phase_t;

    phase_t        state;
    logic [1:0]    sh_mode;
    logic [DW-1:0] sh_peak;
    logic [DW-1:0] sh_step;
    logic [CW-1:0] sh_dwell;
    logic [CW-1:0] cnt;
    logic [DW:0]   sum;
    logic [DW-1:0] step_eff;
    logic          fall_done;
    logic          wrap;

    assign phase = state;

    // A zero step would stall the ramps forever, so it is promoted to 1 at capture.
    assign step_eff = (step == '0) ? {{(DW-1){1'b0}}, 1'b1} : step;
    assign sum      = {1'b0, d_out} + {1'b0, sh_step};

    always_comb begin
        fall_done = 1'b0;
        wrap      = 1'b0;
        if (sh_mode == 2'd2 || sh_mode == 2'd3 || d_out <= sh_step)
            fall_done = 1'b1;
        if (state == FALL && fall_done && (sh_mode == 2'd1 || sh_mode == 2'd2))
            wrap = 1'b1;
        if (state == BOTTOM && cnt == sh_dwell)
            wrap = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            d_out       <= '0;
            state       <= RISE;
            cnt         <= '0;
            period_done <= 1'b0;
            sh_mode     <= mode;
            sh_peak     <= peak;
            sh_step     <= step_eff;
            sh_dwell    <= dwell;
        end else if (!en) begin
            period_done <= 1'b0;
        end else begin
            period_done <= wrap;
            case (state)
                RISE: begin
                    if (sh_mode == 2'd3) begin
                        d_out <= sh_peak;
                        state <= TOP;
                    end else if (sum >= {1'b0, sh_peak}) begin
                        d_out <= sh_peak;
                        state <= (sh_mode == 2'd0) ? TOP : FALL;
                    end else begin
                        d_out <= sum[DW-1:0];
                    end
                end
                TOP: begin
                    if (cnt == sh_dwell) begin
                        cnt   <= '0;
                        state <= FALL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FALL: begin
                    if (fall_done) begin
                        d_out <= '0;
                        state <= (sh_mode == 2'd0 || sh_mode == 2'd3) ? BOTTOM : RISE;
                    end else begin
                        d_out <= d_out - sh_step;
                    end
                end
                BOTTOM: begin
                    if (cnt == sh_dwell) begin
                        cnt   <= '0;
                        state <= RISE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    d_out <= '0;
                    cnt   <= '0;
                    state <= RISE;
                end
            endcase
            // New period begins: latch the live inputs for the whole next period.
            if (wrap) begin
                sh_mode  <= mode;
                sh_peak  <= peak;
                sh_step  <= step_eff;
                sh_dwell <= dwell;
            end
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen: a directed vector table for the short
// trapezoid case, then hand-written period measurements for the long sequences.
module tb_wave_gen;

    logic       clk = 1'b0;
    logic       res;
    logic       en;
    logic [1:0] mode;
    logic [8:0] peak;
    logic [8:0] step;
    logic [7:0] dwell;
    logic [8:0] d_out;
    logic [1:0] phase;
    logic       period_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wave_gen #(.DW(9), .CW(8)) dut (
        .clk         (clk),
        .res         (res),
        .en          (en),
        .mode        (mode),
        .peak        (peak),
        .step        (step),
        .dwell       (dwell),
        .d_out       (d_out),
        .phase       (phase),
        .period_done (period_done)
    );

    typedef struct {
        logic       en;
        logic       res;
        logic [8:0] peak;
        int         exp_d;
        int         exp_ph;
        int         exp_pd;
    } vec_t;

    vec_t vecs[22];

    // Drive en/res, let one rising edge pass, then settle 1 time unit past it.
    task automatic applyStimulus(input logic e, input logic r);
        en  = e;
        res = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic doReset(input logic [1:0] m, input int p, input int s, input int d);
        mode  = m;
        peak  = 9'(p);
        step  = 9'(s);
        dwell = 8'(d);
        applyStimulus(1'b1, 1'b0);
        res = 1'b1;
    endtask

    task automatic waitPulse(input int budget, output int n);
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b1);
            n++;
        end while (period_done !== 1'b1 && n < budget);
        if (period_done !== 1'b1) n = -1;
    endtask

    task automatic waitPhase(input int ph, input int budget, output int n);
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b1);
            n++;
        end while (int'(phase) != ph && n < budget);
        if (int'(phase) != ph) n = -1;
    endtask

    initial begin
        int n;
        int ok;
        en    = 1'b1;
        res   = 1'b0;
        mode  = 2'd0;
        peak  = 9'd100;
        step  = 9'd30;
        dwell = 8'd0;

        // Trapezoid peak 100 step 30 dwell 0, with a freeze, a mid-period peak
        // change to 50 and a reset while disabled.
        vecs[0]  = '{1'b1, 1'b0, 9'd100,   0, 0, 0};
        vecs[1]  = '{1'b1, 1'b1, 9'd100,  30, 0, 0};
        vecs[2]  = '{1'b1, 1'b1, 9'd100,  60, 0, 0};
        vecs[3]  = '{1'b0, 1'b1, 9'd100,  60, 0, 0};
        vecs[4]  = '{1'b1, 1'b1, 9'd100,  90, 0, 0};
        vecs[5]  = '{1'b1, 1'b1, 9'd50,  100, 1, 0};
        vecs[6]  = '{1'b1, 1'b1, 9'd50,  100, 2, 0};
        vecs[7]  = '{1'b1, 1'b1, 9'd50,   70, 2, 0};
        vecs[8]  = '{1'b1, 1'b1, 9'd50,   40, 2, 0};
        vecs[9]  = '{1'b1, 1'b1, 9'd50,   10, 2, 0};
        vecs[10] = '{1'b1, 1'b1, 9'd50,    0, 3, 0};
        vecs[11] = '{1'b1, 1'b1, 9'd50,    0, 0, 1};
        vecs[12] = '{1'b1, 1'b1, 9'd50,   30, 0, 0};
        vecs[13] = '{1'b1, 1'b1, 9'd50,   50, 1, 0};
        vecs[14] = '{1'b1, 1'b1, 9'd50,   50, 2, 0};
        vecs[15] = '{1'b1, 1'b1, 9'd50,   20, 2, 0};
        vecs[16] = '{1'b1, 1'b1, 9'd50,    0, 3, 0};
        vecs[17] = '{1'b1, 1'b1, 9'd50,    0, 0, 1};
        vecs[18] = '{1'b0, 1'b1, 9'd50,    0, 0, 0};
        vecs[19] = '{1'b1, 1'b1, 9'd50,   30, 0, 0};
        vecs[20] = '{1'b0, 1'b0, 9'd50,    0, 0, 0};
        vecs[21] = '{1'b1, 1'b1, 9'd50,   30, 0, 0};

        for (int i = 0; i < 22; i++) begin
            peak = vecs[i].peak;
            applyStimulus(vecs[i].en, vecs[i].res);
            checkOutput($sformatf("vec%0d d_out", i), int'(d_out), vecs[i].exp_d);
            checkOutput($sformatf("vec%0d phase", i), int'(phase), vecs[i].exp_ph);
            checkOutput($sformatf("vec%0d period_done", i), int'(period_done), vecs[i].exp_pd);
        end

        // Long trapezoid: 299 up, 201 top, 299 down, 201 bottom.
        doReset(2'd0, 299, 1, 200);
        waitPhase(1, 2000, n);
        checkOutput("trap rise cycles", n, 299);
        checkOutput("trap top value", int'(d_out), 299);
        waitPhase(2, 2000, n);
        checkOutput("trap top cycles", n, 201);
        waitPulse(2000, n);
        checkOutput("trap first period tail", n, 500);
        waitPulse(2000, n);
        checkOutput("trap period", n, 1000);

        // Freeze for 50 cycles inside TOP; period must stretch by exactly 50.
        waitPhase(1, 2000, n);
        checkOutput("freeze rise cycles", n, 299);
        repeat (10) applyStimulus(1'b1, 1'b1);
        ok = 1;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 1'b1);
            if (d_out !== 9'd299 || phase !== 2'd1 || period_done !== 1'b0) ok = 0;
        end
        checkOutput("freeze held", ok, 1);
        waitPulse(2000, n);
        checkOutput("freeze remaining period", n, 691);

        // One-clock reset in the middle of FALL.
        repeat (600) applyStimulus(1'b1, 1'b1);
        checkOutput("midfall phase", int'(phase), 2);
        checkOutput("midfall d_out", int'(d_out), 199);
        applyStimulus(1'b1, 1'b0);
        checkOutput("reset d_out", int'(d_out), 0);
        checkOutput("reset phase", int'(phase), 0);
        checkOutput("reset period_done", int'(period_done), 0);
        waitPulse(2000, n);
        checkOutput("post reset period", n, 1000);

        // Triangle and sawtooth.
        doReset(2'd1, 299, 1, 200);
        waitPhase(2, 2000, n);
        checkOutput("tri rise cycles", n, 299);
        checkOutput("tri peak", int'(d_out), 299);
        waitPulse(2000, n);
        checkOutput("tri first period tail", n, 299);
        waitPulse(2000, n);
        checkOutput("tri period", n, 598);
        doReset(2'd2, 299, 1, 200);
        waitPulse(2000, n);
        checkOutput("saw first period", n, 300);
        waitPulse(2000, n);
        checkOutput("saw period", n, 300);

        // Mode switched from triangle to sawtooth mid-period: next period only.
        doReset(2'd1, 299, 1, 0);
        repeat (100) applyStimulus(1'b1, 1'b1);
        mode = 2'd2;
        waitPulse(2000, n);
        checkOutput("mode change old period", n, 498);
        waitPulse(2000, n);
        checkOutput("mode change new period", n, 300);

        // Square: 1 rise, 10 high, 1 fall, 10 low.
        doReset(2'd3, 255, 1, 9);
        applyStimulus(1'b1, 1'b1);
        checkOutput("square high value", int'(d_out), 255);
        checkOutput("square high phase", int'(phase), 1);
        waitPulse(200, n);
        checkOutput("square first period tail", n, 21);
        waitPulse(200, n);
        checkOutput("square period", n, 22);

        // Step 0 behaves as step 1.
        doReset(2'd1, 5, 0, 0);
        waitPulse(200, n);
        checkOutput("step zero period", n, 10);

        // Peak 0: all phases visited, output stays 0.
        doReset(2'd0, 0, 4, 2);
        n  = 0;
        ok = 1;
        do begin
            applyStimulus(1'b1, 1'b1);
            n++;
            if (d_out !== 9'd0) ok = 0;
        end while (period_done !== 1'b1 && n < 100);
        checkOutput("peak zero period", n, 8);
        checkOutput("peak zero output", ok, 1);

        // Step larger than peak: one-cycle ramps.
        doReset(2'd1, 10, 50, 0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("big step clamp", int'(d_out), 10);
        waitPulse(200, n);
        checkOutput("big step period tail", n, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_gen.md
WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 SHALL have parameter DW, default 9: width of output sample, peak and step.
REQ-002 SHALL have parameter CW, default 8: width of the dwell count.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 res  input  1  reset, synchronous and active-low: sampled only on posedge clk, asserted when 0.
REQ-005 en  input  1  run enable; 0 freezes all state.
REQ-006 mode  input  2  0 trapezoid, 1 triangle, 2 sawtooth, 3 square.
REQ-007 peak  input  DW  unsigned top level of waveform.
REQ-008 step  input  DW  unsigned increment/decrement per cycle.
REQ-009 dwell  input  CW  flat-section length; flat phase lasts dwell+1 cycles.
REQ-010 d_out  output  DW  registered waveform sample.
REQ-011 phase  output  2  registered FSM state: 0 RISE, 1 TOP, 2 FALL, 3 BOTTOM.
REQ-012 period_done  output  1  registered one-cycle pulse at each period boundary.

Function
REQ-013 mode, peak, step and dwell SHALL be captured into shadow registers during reset and on every cycle period_done is asserted; the FSM SHALL use only the shadow values, so mid-period input changes take effect from the next period.
REQ-014 Shadow step of 0 SHALL be treated as 1.
REQ-015 en=0 SHALL hold d_out, phase, dwell counter, shadow registers and force period_done to 0; en=1 resumes from the held state, no cycles lost or skipped.
REQ-016 RISE, modes 0-2: sum = d_out + step computed in DW+1 bits; if sum >= peak, d_out <= peak and exit RISE; else d_out <= sum and stay.
REQ-017 RISE exit: mode 0 -> TOP, modes 1 and 2 -> FALL.
REQ-018 RISE, mode 3: d_out <= peak in one cycle, -> TOP.
REQ-019 TOP: d_out held; dwell counter increments from 0; when counter == dwell, clear counter and -> FALL; occupies exactly dwell+1 cycles.
REQ-020 FALL, modes 0 and 1: if d_out <= step, d_out <= 0 and exit FALL; else d_out <= d_out - step; no underflow ever occurs.
REQ-021 FALL, modes 2 and 3: d_out <= 0 in one cycle.
REQ-022 FALL exit: modes 0 and 3 -> BOTTOM; modes 1 and 2 -> RISE with period_done.
REQ-023 BOTTOM: d_out held at 0; same counting as TOP; on counter == dwell, clear counter, -> RISE with period_done.
REQ-024 period_done SHALL be 1 exactly on the cycle after the transition into RISE from FALL or BOTTOM (aligned with phase first showing RISE), else 0.
REQ-025 peak=0: RISE exits on first cycle with d_out=0; waveform stays 0 and period still cycles through all phases for its mode.
REQ-026 step >= peak: RISE and FALL each complete in one cycle, d_out clamped to peak/0.
REQ-027 Unreachable/illegal internal state SHALL recover to RISE, d_out 0, counter 0 on the next enabled cycle.

Reset
REQ-028 On posedge clk with res=0: d_out=0, phase=RISE, dwell counter=0, period_done=0, shadows loaded from inputs; applies regardless of en or current phase.
REQ-029 Reset asserted mid-period SHALL abandon the period without a period_done pulse; first RISE cycle follows the first posedge with res=1.

Verification
REQ-030 mode=0, peak=299, step=1, dwell=200, en=1: d_out 0->299 in 299 cycles, holds 299 for 201 cycles, 299->0 in 299 cycles, holds 0 for 201; period_done every 1000 cycles.
REQ-031 mode=1, peak=299, step=1: symmetric triangle 0..299..0, no flat phases, period_done every 598 cycles; mode=2 same peak: ramp then single-cycle drop to 0, period 300.
REQ-032 mode=3, peak=255, dwell=9: 1 cycle RISE, 10 cycles at 255, 1 cycle FALL, 10 cycles at 0; period 22.
REQ-033 mode=0, peak=100, step=30, dwell=0: d_out 30,60,90,100,100,70,40,10,0,0 then repeats; changing peak to 50 mid-period alters only the next period.
REQ-034 en dropped for 50 cycles during TOP: d_out, phase, counter frozen, no period_done; total period extends by exactly 50 cycles.
REQ-035 res=0 for one clock mid-FALL: next cycle d_out=0, phase=RISE, period_done=0; normal 1000-cycle periods resume.
